// File: rtl/collision_resolve.sv
// Pac-Man collision resolver: turns per-step collision strobes into score,
// lives, item clearing, power mode and end-of-game state.
module collision_resolve #(
    parameter int DOT_POINTS   = 10,
    parameter int PILL_POINTS  = 50,
    parameter int GHOST_POINTS = 200,
    parameter int POWER_CYCLES = 400_000_000,
    parameter int DEATH_CYCLES = 50_000_000,
    parameter int LIVES_INIT   = 3,
    parameter int ITEM_TOTAL   = 244
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        collision_valid,
    input  logic [3:0]  collision_type,
    input  logic [5:0]  pacman_x,
    input  logic [4:0]  pacman_y,
    input  logic        clear_ack,
    output logic        clear_req,
    output logic [5:0]  clear_x,
    output logic [4:0]  clear_y,
    output logic        move_allow,
    output logic [1:0]  ghost_eaten,
    output logic [19:0] score,
    output logic [1:0]  lives,
    output logic [7:0]  items_left,
    output logic        power_mode,
    output logic        dying,
    output logic        game_over,
    output logic        level_clear
);

    localparam logic [2:0] PLAY  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] DYING = 3'd2;
    localparam logic [2:0] OVER  = 3'd3;
    localparam logic [2:0] WIN   = 3'd4;

    localparam logic [3:0] T_NONE = 4'd0;
    localparam logic [3:0] T_DOT  = 4'd2;
    localparam logic [3:0] T_PILL = 4'd3;
    localparam logic [3:0] T_G1   = 4'd4;
    localparam logic [3:0] T_G2   = 4'd5;

    localparam logic [19:0] SCORE_MAX = 20'hFFFFF;

    logic [2:0]  state;
    logic [31:0] power_cnt;
    logic [31:0] power_next;
    logic [31:0] death_cnt;
    logic        play_hit;
    logic        is_ghost;
    logic        ghost_kill;
    logic        pill_take;
    logic        win_enter;

    function automatic logic [19:0] sat_add(input logic [19:0] a,
                                            input logic [19:0] b);
        logic [20:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[20] ? SCORE_MAX : s[19:0];
    endfunction

    assign play_hit   = (state == PLAY) && collision_valid;
    assign is_ghost   = (collision_type == T_G1) || (collision_type == T_G2);
    assign ghost_kill = play_hit && is_ghost && !power_mode;
    assign pill_take  = play_hit && (collision_type == T_PILL);
    assign win_enter  = (state == CLEAR) && clear_ack && (items_left == 8'd0);

    // Next power-timer value: run down while playing, reload on a pill,
    // and drop to zero whenever the game leaves active play.
    always_comb begin
        power_next = power_cnt;
        if ((state == PLAY || state == CLEAR) && power_cnt != 32'd0)
            power_next = power_cnt - 32'd1;
        if (pill_take)
            power_next = 32'(POWER_CYCLES);
        if (ghost_kill || win_enter)
            power_next = 32'd0;
    end

    // Power timer and its registered "ghosts are edible" flag.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            power_cnt  <= 32'd0;
            power_mode <= 1'b0;
        end else begin
            power_cnt  <= power_next;
            power_mode <= (power_next != 32'd0);
        end
    end

    // Game state machine: scoring, item clearing, lives and death timing.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= PLAY;
            score       <= 20'd0;
            lives       <= 2'(LIVES_INIT);
            items_left  <= 8'(ITEM_TOTAL);
            clear_req   <= 1'b0;
            clear_x     <= 6'd0;
            clear_y     <= 5'd0;
            move_allow  <= 1'b0;
            ghost_eaten <= 2'b00;
            dying       <= 1'b0;
            game_over   <= 1'b0;
            level_clear <= 1'b0;
            death_cnt   <= 32'd0;
        end else begin
            move_allow  <= 1'b0;
            ghost_eaten <= 2'b00;
            case (state)
                PLAY: begin
                    if (collision_valid) begin
                        case (collision_type)
                            T_NONE: move_allow <= 1'b1;
                            T_DOT, T_PILL: begin
                                move_allow <= 1'b1;
                                score <= sat_add(score,
                                    (collision_type == T_PILL) ?
                                    20'(PILL_POINTS) : 20'(DOT_POINTS));
                                if (items_left != 8'd0)
                                    items_left <= items_left - 8'd1;
                                clear_x   <= pacman_x;
                                clear_y   <= pacman_y;
                                clear_req <= 1'b1;
                                state     <= CLEAR;
                            end
                            T_G1, T_G2: begin
                                if (power_mode) begin
                                    move_allow <= 1'b1;
                                    score <= sat_add(score,
                                        20'(GHOST_POINTS));
                                    ghost_eaten <=
                                        (collision_type == T_G1) ?
                                        2'b01 : 2'b10;
                                end else begin
                                    if (lives != 2'd0)
                                        lives <= lives - 2'd1;
                                    if (lives <= 2'd1) begin
                                        state     <= OVER;
                                        game_over <= 1'b1;
                                    end else begin
                                        state     <= DYING;
                                        dying     <= 1'b1;
                                        death_cnt <= 32'(DEATH_CYCLES);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (clear_ack) begin
                        clear_req <= 1'b0;
                        if (items_left == 8'd0) begin
                            state       <= WIN;
                            level_clear <= 1'b1;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                DYING: begin
                    if (death_cnt <= 32'd1) begin
                        death_cnt <= 32'd0;
                        dying     <= 1'b0;
                        state     <= PLAY;
                    end else begin
                        death_cnt <= death_cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_resolve.sv
// Scoreboard bench for collision_resolve: each driven step pushes its
// expected outcome, which is popped and compared one edge later.
module tb_collision_resolve;

    logic        clk;
    logic        rst_n;
    logic        collision_valid;
    logic [3:0]  collision_type;
    logic [5:0]  pacman_x;
    logic [4:0]  pacman_y;
    logic        clear_ack;
    logic        clear_req;
    logic [5:0]  clear_x;
    logic [4:0]  clear_y;
    logic        move_allow;
    logic [1:0]  ghost_eaten;
    logic [19:0] score;
    logic [1:0]  lives;
    logic [7:0]  items_left;
    logic        power_mode;
    logic        dying;
    logic        game_over;
    logic        level_clear;

    int n_run;
    int n_fail;

    typedef struct {
        logic        mv;
        logic [1:0]  ge;
        logic [19:0] sc;
        logic [1:0]  lv;
        logic [7:0]  it;
        logic        cr;
        logic        pm;
        logic        dy;
        logic        ov;
        logic        lc;
    } exp_t;

    exp_t sb[$];

    collision_resolve #(
        .POWER_CYCLES(20),
        .DEATH_CYCLES(8),
        .LIVES_INIT(2),
        .ITEM_TOTAL(2)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst_n),
        .collision_valid(collision_valid),
        .collision_type(collision_type),
        .pacman_x(pacman_x),
        .pacman_y(pacman_y),
        .clear_ack(clear_ack),
        .clear_req(clear_req),
        .clear_x(clear_x),
        .clear_y(clear_y),
        .move_allow(move_allow),
        .ghost_eaten(ghost_eaten),
        .score(score),
        .lives(lives),
        .items_left(items_left),
        .power_mode(power_mode),
        .dying(dying),
        .game_over(game_over),
        .level_clear(level_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic mv, input logic [1:0] ge,
                                input logic [19:0] sc, input logic [1:0] lv,
                                input logic [7:0] it, input logic cr,
                                input logic pm, input logic dy,
                                input logic ov, input logic lc);
        exp_t e;
        e.mv = mv; e.ge = ge; e.sc = sc; e.lv = lv; e.it = it;
        e.cr = cr; e.pm = pm; e.dy = dy; e.ov = ov; e.lc = lc;
        return e;
    endfunction

    task automatic step(input logic v, input logic [3:0] t,
                        input logic [5:0] x, input logic [4:0] y,
                        input logic ack, input exp_t e);
        exp_t g;
        @(negedge clk);
        collision_valid = v;
        collision_type  = t;
        pacman_x        = x;
        pacman_y        = y;
        clear_ack       = ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        collision_valid = 1'b0;
        clear_ack       = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk("move_allow",  32'(move_allow),  32'(g.mv));
            chk("ghost_eaten", 32'(ghost_eaten), 32'(g.ge));
            chk("score",       32'(score),       32'(g.sc));
            chk("lives",       32'(lives),       32'(g.lv));
            chk("items_left",  32'(items_left),  32'(g.it));
            chk("clear_req",   32'(clear_req),   32'(g.cr));
            chk("power_mode",  32'(power_mode),  32'(g.pm));
            chk("dying",       32'(dying),       32'(g.dy));
            chk("game_over",   32'(game_over),   32'(g.ov));
            chk("level_clear", 32'(level_clear), 32'(g.lc));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".score"}, 32'(score), 32'd0);
        chk({tag, ".lives"}, 32'(lives), 32'd2);
        chk({tag, ".items"}, 32'(items_left), 32'd2);
        chk({tag, ".clear_req"}, 32'(clear_req), 32'd0);
        chk({tag, ".move"}, 32'(move_allow), 32'd0);
        chk({tag, ".power"}, 32'(power_mode), 32'd0);
        chk({tag, ".dying"}, 32'(dying), 32'd0);
        chk({tag, ".over"}, 32'(game_over), 32'd0);
        chk({tag, ".clear"}, 32'(level_clear), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        collision_valid = 1'b0;
        collision_type  = 4'd0;
        pacman_x = 6'd0;
        pacman_y = 5'd0;
        clear_ack = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        collision_valid = 1'b0;
        collision_type  = 4'd0;
        pacman_x  = 6'd0;
        pacman_y  = 5'd0;
        clear_ack = 1'b0;

        // Basic moves, walls, ignored types, dot with delayed ack
        do_reset();
        step(1, 4'd0, 0, 0, 0, mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 0));
        step(1, 4'd1, 0, 0, 0, mk(0, 0, 0, 2, 2, 0, 0, 0, 0, 0));
        step(1, 4'd7, 0, 0, 0, mk(0, 0, 0, 2, 2, 0, 0, 0, 0, 0));
        step(1, 4'd15, 0, 0, 0, mk(0, 0, 0, 2, 2, 0, 0, 0, 0, 0));
        step(1, 4'd0, 0, 0, 1, mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 0));
        step(1, 4'd2, 5, 7, 0, mk(1, 0, 10, 2, 1, 1, 0, 0, 0, 0));
        chk("clear_x", 32'(clear_x), 32'd5);
        chk("clear_y", 32'(clear_y), 32'd7);
        step(1, 4'd2, 9, 9, 0, mk(0, 0, 10, 2, 1, 1, 0, 0, 0, 0));
        chk("clear_x_hold", 32'(clear_x), 32'd5);
        chk("clear_y_hold", 32'(clear_y), 32'd7);
        step(0, 4'd0, 0, 0, 0, mk(0, 0, 10, 2, 1, 1, 0, 0, 0, 0));
        step(0, 4'd0, 0, 0, 1, mk(0, 0, 10, 2, 1, 0, 0, 0, 0, 0));
        step(1, 4'd0, 0, 0, 0, mk(1, 0, 10, 2, 1, 0, 0, 0, 0, 0));

        // Pill, powered ghost hits (incl. last powered cycle), death
        do_reset();
        step(1, 4'd3, 1, 1, 0, mk(1, 0, 50, 2, 1, 1, 1, 0, 0, 0));
        step(0, 4'd0, 0, 0, 1, mk(0, 0, 50, 2, 1, 0, 1, 0, 0, 0));
        idle(8);
        step(1, 4'd4, 0, 0, 0, mk(1, 2'b01, 250, 2, 1, 0, 1, 0, 0, 0));
        step(0, 4'd0, 0, 0, 0, mk(0, 0, 250, 2, 1, 0, 1, 0, 0, 0));
        idle(8);
        step(1, 4'd4, 0, 0, 0, mk(1, 2'b01, 450, 2, 1, 0, 0, 0, 0, 0));
        idle(4);
        step(1, 4'd5, 0, 0, 0, mk(0, 0, 450, 1, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            step(0, 4'd0, 0, 0, 0, mk(0, 0, 450, 1, 1, 0, 0, 1, 0, 0));
        step(0, 4'd0, 0, 0, 0, mk(0, 0, 450, 1, 1, 0, 0, 0, 0, 0));
        step(1, 4'd0, 0, 0, 0, mk(1, 0, 450, 1, 1, 0, 0, 0, 0, 0));

        // Two unpowered hits -> game over, then everything ignored
        do_reset();
        step(1, 4'd4, 0, 0, 0, mk(0, 0, 0, 1, 2, 0, 0, 1, 0, 0));
        idle(8);
        step(1, 4'd0, 0, 0, 0, mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        step(1, 4'd5, 0, 0, 0, mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        step(1, 4'd2, 3, 3, 0, mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        step(1, 4'd4, 0, 0, 0, mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0));

        // Eat both items -> level clear; then async reset mid-clear
        do_reset();
        step(1, 4'd2, 2, 3, 0, mk(1, 0, 10, 2, 1, 1, 0, 0, 0, 0));
        step(0, 4'd0, 0, 0, 1, mk(0, 0, 10, 2, 1, 0, 0, 0, 0, 0));
        step(1, 4'd3, 4, 4, 0, mk(1, 0, 60, 2, 0, 1, 1, 0, 0, 0));
        step(0, 4'd0, 0, 0, 1, mk(0, 0, 60, 2, 0, 0, 0, 0, 0, 1));
        step(1, 4'd0, 0, 0, 0, mk(0, 0, 60, 2, 0, 0, 0, 0, 0, 1));
        do_reset();
        step(1, 4'd2, 6, 6, 0, mk(1, 0, 10, 2, 1, 1, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'd0, 0, 0, 0, mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_resolve.md
COLLISION_RESOLVE -- requirements
Module: collision_resolve

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- DOT_POINTS, 10, score added per dot
- PILL_POINTS, 50, score added per pill
- GHOST_POINTS, 200, score added per eaten ghost
- POWER_CYCLES, 400_000_000, power-mode duration in clocks
- DEATH_CYCLES, 50_000_000, dying-animation duration in clocks
- LIVES_INIT, 3, lives after reset (1..3)
- ITEM_TOTAL, 244, dots plus pills on a fresh map (1..255)
REQ-002 Ports SHALL be (name direction width meaning), one per line:
- CLOCK_50 in 1 system clock; one clock domain, all logic on its rising edge
- reset in 1 asynchronous, active-low reset
- collision_valid in 1 one-cycle strobe qualifying collision_type for one move step
- collision_type in 4 0 none, 1 wall, 2 dot, 3 pill, 4 ghost one, 5 ghost two
- pacman_x in 6 pacman tile column for the step
- pacman_y in 5 pacman tile row for the step
- clear_ack in 1 map memory has removed the item
- clear_req out 1 request to remove item at clear_x/clear_y
- clear_x out 6 latched tile column to clear
- clear_y out 5 latched tile row to clear
- move_allow out 1 one-cycle pulse: pacman may commit the step
- ghost_eaten out 2 one-cycle pulse, bit0 ghost one, bit1 ghost two
- score out 20 running score
- lives out 2 remaining lives
- items_left out 8 dots plus pills not yet eaten
- power_mode out 1 ghosts currently edible
- dying out 1 death sequence in progress
- game_over out 1 lives exhausted
- level_clear out 1 all items eaten

Function
REQ-003 FSM SHALL have states PLAY, CLEAR, DYING, OVER, WIN; only PLAY accepts collision_valid; strobes in any other state are ignored.
REQ-004 All outputs SHALL be registered; every response appears the cycle after the collision_valid sample.
REQ-005 PLAY, type 0: move_allow pulses; nothing else changes.
REQ-006 PLAY, type 1 (wall): move_allow stays 0; no other change.
REQ-007 PLAY, type 2 (dot): move_allow pulses, score += DOT_POINTS, items_left -= 1, clear_x/clear_y latch pacman_x/pacman_y, clear_req rises, state -> CLEAR.
REQ-008 PLAY, type 3 (pill): as REQ-007 with PILL_POINTS; power timer loads POWER_CYCLES, reloading if already running.
REQ-009 PLAY, type 4/5 with power_mode=1: move_allow pulses, score += GHOST_POINTS, matching ghost_eaten bit pulses.
REQ-010 PLAY, type 4/5 with power_mode=0: lives -= 1; if result is 0 -> OVER, else -> DYING with death counter loaded DEATH_CYCLES; move_allow stays 0.
REQ-011 Types 6..15 SHALL be ignored (no output change).
REQ-012 CLEAR: clear_req, clear_x, clear_y held stable until clear_ack is sampled high; clear_req falls the next cycle; state -> WIN if items_left is 0, else PLAY; clear_ack outside CLEAR ignored.
REQ-013 power_mode SHALL equal (power timer != 0); timer decrements by 1 per cycle in PLAY and CLEAR, clears to 0 on entry to DYING, OVER or WIN.
REQ-014 Ghost collision SHALL use the registered power_mode value of the sampling cycle, even if the timer reaches 0 that same cycle.
REQ-015 DYING: dying=1; counter decrements each cycle; on reaching 0, dying falls and state -> PLAY.
REQ-016 score SHALL saturate at 1_048_575; items_left and lives SHALL never wrap below 0.
REQ-017 OVER asserts game_over, WIN asserts level_clear; both are terminal until reset.

Reset
REQ-018 reset low SHALL asynchronously force state PLAY, score 0, lives LIVES_INIT, items_left ITEM_TOTAL, all timers and other outputs 0, including mid-CLEAR and mid-DYING.
REQ-019 Outputs SHALL leave reset values only on the first rising edge after reset returns high.

Verification (POWER_CYCLES=20, DEATH_CYCLES=8, ITEM_TOTAL=2, LIVES_INIT=2)
REQ-020 Dot at (5,7), clear_ack after 3 cycles -> score 10, items_left 1, clear_req high 3 cycles with (5,7), then PLAY.
REQ-021 Pill then ghost one at cycle 10 -> score 250, ghost_eaten=01 pulse; ghost two at cycle 25 -> lives 1, dying high 8 cycles.
REQ-022 Wall strobe -> move_allow stays 0, score unchanged; strobe while in CLEAR -> ignored.
REQ-023 Two unpowered ghost hits -> lives 0, game_over=1; later strobes ignored.
REQ-024 Both items eaten and acked -> level_clear=1; reset low mid-CLEAR -> clear_req 0 and items_left 2 immediately.
